// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b types and reorder-buffer entry layout
package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'd0,
        op_add  = 4'd1,
        op_ldb  = 4'd2,
        op_stb  = 4'd3,
        op_jsr  = 4'd4,
        op_and  = 4'd5,
        op_ldr  = 4'd6,
        op_str  = 4'd7,
        op_rti  = 4'd8,
        op_not  = 4'd9,
        op_ldi  = 4'd10,
        op_sti  = 4'd11,
        op_jmp  = 4'd12,
        op_shf  = 4'd13,
        op_lea  = 4'd14,
        op_trap = 4'd15
    } lc3b_opcode;

    typedef logic [2:0]  lc3b_reg;
    typedef logic [15:0] lc3b_word;

    localparam int ROB_TAG_WIDTH = 3;
    localparam int ROB_DEPTH     = 2 ** ROB_TAG_WIDTH;

    typedef logic [ROB_TAG_WIDTH-1:0] lc3b_rob_addr;

    typedef struct packed {
        logic       busy;
        logic       ready;
        lc3b_opcode opcode;
        lc3b_reg    dest;
        logic       predict;
        lc3b_word   value;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// rtl/rob_ptr.sv - wrapping reorder-buffer pointer with increment and clear
module rob_ptr #(
    parameter int width = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [width-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular reorder buffer with CDB capture, commit and operand lookup
// Optional same-cycle CDB-to-lookup forwarding: ROB_CDB_FORWARD_EN
module reorder_buffer
    import lc3b_types::*;
#(
    parameter int data_width = 16,
    parameter int tag_width  = ROB_TAG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc,
    input  lc3b_opcode            alloc_opcode,
    input  lc3b_reg               alloc_dest,
    input  logic                  alloc_predict,
    output lc3b_rob_addr          alloc_tag,
    output logic                  rob_full,
    input  logic                  cdb_valid,
    input  lc3b_rob_addr          cdb_tag,
    input  logic [data_width-1:0] cdb_value,
    input  lc3b_rob_addr          rd_tag_a,
    input  lc3b_rob_addr          rd_tag_b,
    output logic                  rd_ready_a,
    output logic                  rd_ready_b,
    output logic [data_width-1:0] rd_value_a,
    output logic [data_width-1:0] rd_value_b,
    output logic                  valid_out,
    output lc3b_opcode            opcode_out,
    output lc3b_reg               dest_out,
    output logic                  predict_out,
    output logic [data_width-1:0] value_out,
    output lc3b_rob_addr          head_tag,
    output logic                  rob_empty,
    input  logic                  RE,
    input  logic                  flush
);

    localparam int depth = 2 ** tag_width;

    rob_entry_t       rob [depth];
    lc3b_rob_addr     head;
    lc3b_rob_addr     tail;
    logic [tag_width:0] count;
    rob_entry_t       head_e;
    logic             do_alloc;
    logic             do_retire;

    assign head_e    = rob[head];
    assign rob_empty = (count == '0);
    assign rob_full  = (count == (tag_width + 1)'(depth));
    assign valid_out = head_e.busy & head_e.ready;
    assign do_alloc  = alloc & ~rob_full & ~flush;
    assign do_retire = RE & valid_out & ~flush;

    assign alloc_tag   = tail;
    assign head_tag    = head;
    assign opcode_out  = head_e.opcode;
    assign dest_out    = head_e.dest;
    assign predict_out = head_e.predict;
    assign value_out   = data_width'(head_e.value);

    rob_ptr #(.width(tag_width)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (do_retire),
        .clr   (flush),
        .ptr   (head)
    );

    rob_ptr #(.width(tag_width)) u_tail (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (do_alloc),
        .clr   (flush),
        .ptr   (tail)
    );

    // Retire and allocate never touch the same slot: they coincide only when full, where alloc is refused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int i = 0; i < depth; i++) begin
                rob[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
            for (int i = 0; i < depth; i++) begin
                rob[i].busy  <= 1'b0;
                rob[i].ready <= 1'b0;
            end
        end else begin
            if (cdb_valid && rob[cdb_tag].busy) begin
                rob[cdb_tag].ready <= 1'b1;
                rob[cdb_tag].value <= lc3b_word'(cdb_value);
            end
            if (do_retire) begin
                rob[head].busy <= 1'b0;
            end
            if (do_alloc) begin
                rob[tail].busy    <= 1'b1;
                rob[tail].ready   <= 1'b0;
                rob[tail].opcode  <= alloc_opcode;
                rob[tail].dest    <= alloc_dest;
                rob[tail].predict <= alloc_predict;
            end
            if (do_alloc && !do_retire) begin
                count <= count + 1'b1;
            end else if (!do_alloc && do_retire) begin
                count <= count - 1'b1;
            end
        end
    end

    always_comb begin
        rd_ready_a = rob[rd_tag_a].busy & rob[rd_tag_a].ready;
        rd_value_a = data_width'(rob[rd_tag_a].value);
        rd_ready_b = rob[rd_tag_b].busy & rob[rd_tag_b].ready;
        rd_value_b = data_width'(rob[rd_tag_b].value);
`ifdef ROB_CDB_FORWARD_EN
        if (cdb_valid && rob[cdb_tag].busy && (cdb_tag == rd_tag_a)) begin
            rd_ready_a = 1'b1;
            rd_value_a = cdb_value;
        end
        if (cdb_valid && rob[cdb_tag].busy && (cdb_tag == rd_tag_b)) begin
            rd_ready_b = 1'b1;
            rd_value_b = cdb_value;
        end
`else
`endif
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed and randomized bench for reorder_buffer against a queue model
module tb_reorder_buffer;
    import lc3b_types::*;

    logic         clk;
    logic         rst_n;
    logic         alloc;
    lc3b_opcode   alloc_opcode;
    lc3b_reg      alloc_dest;
    logic         alloc_predict;
    lc3b_rob_addr alloc_tag;
    logic         rob_full;
    logic         cdb_valid;
    lc3b_rob_addr cdb_tag;
    logic [15:0]  cdb_value;
    lc3b_rob_addr rd_tag_a;
    lc3b_rob_addr rd_tag_b;
    logic         rd_ready_a;
    logic         rd_ready_b;
    logic [15:0]  rd_value_a;
    logic [15:0]  rd_value_b;
    logic         valid_out;
    lc3b_opcode   opcode_out;
    lc3b_reg      dest_out;
    logic         predict_out;
    logic [15:0]  value_out;
    lc3b_rob_addr head_tag;
    logic         rob_empty;
    logic         re;
    logic         flush;

    int total = 0;
    int bad   = 0;

    // Model: program-ordered queue of occupied slot numbers plus per-slot field storage.
    int q[$];
    int m_head;
    bit m_ready[8];
    int m_val[8];
    int m_op[8];
    int m_dest[8];
    bit m_pred[8];

    reorder_buffer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc         (alloc),
        .alloc_opcode  (alloc_opcode),
        .alloc_dest    (alloc_dest),
        .alloc_predict (alloc_predict),
        .alloc_tag     (alloc_tag),
        .rob_full      (rob_full),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_value     (cdb_value),
        .rd_tag_a      (rd_tag_a),
        .rd_tag_b      (rd_tag_b),
        .rd_ready_a    (rd_ready_a),
        .rd_ready_b    (rd_ready_b),
        .rd_value_a    (rd_value_a),
        .rd_value_b    (rd_value_b),
        .valid_out     (valid_out),
        .opcode_out    (opcode_out),
        .dest_out      (dest_out),
        .predict_out   (predict_out),
        .value_out     (value_out),
        .head_tag      (head_tag),
        .rob_empty     (rob_empty),
        .RE            (re),
        .flush         (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_q(input int t);
        foreach (q[i]) if (q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_head = 0;
        for (int i = 0; i < 8; i++) begin
            m_ready[i] = 0; m_val[i] = 0; m_op[i] = 0; m_dest[i] = 0; m_pred[i] = 0;
        end
    endtask

    task automatic check_outputs(input bit cv, input int ct, input int cval, input int ta, input int tb);
        int sz;
        bit er_a, er_b;
        int ev_a, ev_b;
        sz = q.size();
        check("rob_full", 32'(rob_full), 32'(sz == 8));
        check("rob_empty", 32'(rob_empty), 32'(sz == 0));
        check("alloc_tag", 32'(alloc_tag), 32'((m_head + sz) % 8));
        check("head_tag", 32'(head_tag), 32'(m_head));
        check("valid_out", 32'(valid_out), 32'(sz > 0 && m_ready[m_head]));
        check("opcode_out", 32'(opcode_out), 32'(m_op[m_head]));
        check("dest_out", 32'(dest_out), 32'(m_dest[m_head]));
        check("predict_out", 32'(predict_out), 32'(m_pred[m_head]));
        check("value_out", 32'(value_out), 32'(m_val[m_head]));
        er_a = in_q(ta) && m_ready[ta];
        ev_a = m_val[ta];
        er_b = in_q(tb) && m_ready[tb];
        ev_b = m_val[tb];
`ifdef ROB_CDB_FORWARD_EN
        if (cv && ct == ta && in_q(ct)) begin er_a = 1; ev_a = cval; end
        if (cv && ct == tb && in_q(ct)) begin er_b = 1; ev_b = cval; end
`else
`endif
        check("rd_ready_a", 32'(rd_ready_a), 32'(er_a));
        check("rd_value_a", 32'(rd_value_a), 32'(ev_a));
        check("rd_ready_b", 32'(rd_ready_b), 32'(er_b));
        check("rd_value_b", 32'(rd_value_b), 32'(ev_b));
    endtask

    task automatic model_edge(input bit a, input int op, input int dst, input bit pr,
                              input bit cv, input int ct, input int cval, input bit r, input bit fl);
        int sz, t;
        bit ret, acc;
        if (fl) begin
            q.delete();
            m_head = 0;
            for (int i = 0; i < 8; i++) m_ready[i] = 0;
            return;
        end
        sz  = q.size();
        ret = r && sz > 0 && m_ready[m_head];
        acc = a && sz < 8;
        t   = (m_head + sz) % 8;
        if (cv && in_q(ct)) begin
            m_ready[ct] = 1;
            m_val[ct]   = cval;
        end
        if (ret) begin
            void'(q.pop_front());
            m_head = (m_head + 1) % 8;
        end
        if (acc) begin
            m_op[t] = op; m_dest[t] = dst; m_pred[t] = pr; m_ready[t] = 0;
            q.push_back(t);
        end
    endtask

    task automatic step(input bit a, input int op, input int dst, input bit pr,
                        input bit cv, input int ct, input int cval,
                        input int ta, input int tb, input bit r, input bit fl);
        alloc         = a;
        alloc_opcode  = lc3b_opcode'(4'(op));
        alloc_dest    = lc3b_reg'(dst);
        alloc_predict = pr;
        cdb_valid     = cv;
        cdb_tag       = lc3b_rob_addr'(ct);
        cdb_value     = 16'(cval);
        rd_tag_a      = lc3b_rob_addr'(ta);
        rd_tag_b      = lc3b_rob_addr'(tb);
        re            = r;
        flush         = fl;
        #4;
        check_outputs(cv, ct, cval, ta, tb);
        @(posedge clk);
        model_edge(a, op, dst, pr, cv, ct, cval, r, fl);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_empty", 32'(rob_empty), 32'd1);
        check("rst_full", 32'(rob_full), 32'd0);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_alloc_tag", 32'(alloc_tag), 32'd0);
        check("rst_head_tag", 32'(head_tag), 32'd0);
        check("rst_rd_ready_a", 32'(rd_ready_a), 32'd0);
        check("rst_rd_ready_b", 32'(rd_ready_b), 32'd0);
        check("rst_rd_value_a", 32'(rd_value_a), 32'd0);
        check("rst_value_out", 32'(value_out), 32'd0);
        check("rst_opcode_out", 32'(opcode_out), 32'd0);
        check("rst_dest_out", 32'(dest_out), 32'd0);
        check("rst_predict_out", 32'(predict_out), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        alloc = 0; alloc_opcode = op_br; alloc_dest = '0; alloc_predict = 0;
        cdb_valid = 0; cdb_tag = '0; cdb_value = '0;
        rd_tag_a = '0; rd_tag_b = '0; re = 0; flush = 0;
        model_reset();
        @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;

        // Fill all eight slots, then one refused allocation.
        for (int i = 0; i < 8; i++) begin
            check("fill_alloc_tag", 32'(alloc_tag), 32'(i));
            step(1, int'(op_add), i, i[0], 0, 0, 0, i, 7 - i, 0, 0);
        end
        check("full_after_8", 32'(rob_full), 32'd1);
        step(1, int'(op_and), 5, 1, 0, 0, 0, 0, 1, 0, 0);
        check("ninth_ignored_tag", 32'(alloc_tag), 32'd0);

        // Out-of-order completion: tag 2 first, head becomes valid only after tag 0.
        step(0, 0, 0, 0, 1, 2, 16'h1234, 2, 0, 0, 0);
        check("head_not_ready", 32'(valid_out), 32'd0);
        step(0, 0, 0, 0, 1, 0, 16'h0042, 0, 2, 0, 0);
        check("head_valid", 32'(valid_out), 32'd1);
        check("head_value", 32'(value_out), 32'h0042);

        // Full with ready head: retire wins, allocation refused, then wrap to tag 0.
        step(1, int'(op_not), 3, 0, 0, 0, 0, 0, 2, 1, 0);
        check("retire_full_count", 32'(rob_full), 32'd0);
        check("retire_full_tag", 32'(alloc_tag), 32'd0);
        step(1, int'(op_ldr), 4, 1, 0, 0, 0, 1, 2, 0, 0);

        // Reduce to five occupied entries, then flush with everything asserted.
        step(0, 0, 0, 0, 1, 1, 16'h0101, 1, 3, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0);
        step(0, 0, 0, 0, 1, 3, 16'h0303, 2, 3, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 3, 4, 1, 0);
        check("five_left_head", 32'(head_tag), 32'd4);
        step(1, int'(op_lea), 2, 0, 1, 5, 16'h5555, 5, 4, 1, 1);
        check("flush_empty", 32'(rob_empty), 32'd1);
        check("flush_alloc_tag", 32'(alloc_tag), 32'd0);

        // Lookup of tag 3 while the CDB delivers it (forwarded or one cycle later).
        for (int i = 0; i < 4; i++) step(1, int'(op_add), i, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 3, 16'hBEEF, 3, 3, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 3, 2, 0, 0);
        check("lookup_late_ready", 32'(rd_ready_a), 32'd1);
        check("lookup_late_value", 32'(rd_value_a), 32'hBEEF);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 9) < 6, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 65535)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 3);
        end

        // Asynchronous reset with three busy entries.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, int'(op_trap), i + 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 16'h7777, 1, 0, 0, 0);
        rd_tag_a = 3'd1; rd_tag_b = 3'd0; cdb_valid = 0; alloc = 1; re = 1;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        alloc = 0; re = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            step($urandom_range(0, 1) == 1, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 65535)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 $urandom_range(0, 1) == 1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer between the issue stage and the commit/write-results stage of the out-of-order LC-3b core. Allocates one entry per issued instruction in program order, captures results broadcast on the CDB by tag, and presents the oldest entry to commit. Also serves two operand-lookup ports for reservation stations and clears entirely on a mispredict or trap flush.

## Interface
Parameters:
- data_width, 16, width of the result value field
- tag_width, 3, ROB tag width; depth = 2**tag_width entries

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- alloc  in  1  allocate an entry at the tail this cycle
- alloc_opcode  in  lc3b_opcode  opcode of the issuing instruction
- alloc_dest  in  lc3b_reg  destination register, or nzp for branches
- alloc_predict  in  1  predicted-taken bit for branches
- alloc_tag  out  lc3b_rob_addr  tail index the next allocation receives
- rob_full  out  1  no free entry
- cdb_valid  in  1  result broadcast present
- cdb_tag  in  lc3b_rob_addr  entry the result belongs to
- cdb_value  in  data_width  result value or branch target
- rd_tag_a, rd_tag_b  in  lc3b_rob_addr  operand lookup tags
- rd_ready_a, rd_ready_b  out  1  looked-up entry holds its result
- rd_value_a, rd_value_b  out  data_width  looked-up entry's value
- valid_out  out  1  head entry is occupied and ready to commit
- opcode_out, dest_out, predict_out, value_out  out  head entry fields
- head_tag  out  lc3b_rob_addr  index of the head entry
- rob_empty  out  1  no occupied entries
- RE  in  1  commit stage retires the head this cycle
- flush  in  1  discard all entries

## Operation
- Entry state: busy, ready, opcode, dest, predict, value.
- Pointers head and tail are tag_width bits wide and wrap modulo depth; count is tag_width+1 bits wide and runs 0..depth.
- rob_empty = (count == 0); rob_full = (count == depth).
- Allocate: if alloc and not rob_full, the tail entry is written with busy=1, ready=0, and the opcode/dest/predict fields. tail then increments. alloc while rob_full is ignored.
- CDB write: if cdb_valid and entry[cdb_tag].busy, set ready=1 and value=cdb_value. A write to a non-busy entry is ignored.
- Commit: valid_out = busy[head] & ready[head]. The head fields drive the outputs combinationally from registered state. If RE and valid_out, clear busy[head] and increment head. RE without valid_out is ignored.
- Count update: +1 on an accepted allocation, -1 on an accepted retire; both in the same cycle leave count unchanged.
- Allocation and retire in the same cycle are legal at every count except full, where allocation is refused even if RE is asserted.
- Flush has priority over all other operations: clear every busy/ready bit, and set head = tail = count = 0. The alloc, CDB and RE inputs in that cycle are discarded.
- Lookup: rd_ready_x = busy[rd_tag_x] & ready[rd_tag_x]; rd_value_x = value[rd_tag_x].

## Timing
- Allocation, CDB write, retire and flush all take effect at the next rising edge.
- alloc_tag, rob_full and rob_empty reflect registered state only.
- A result written by the CDB becomes visible on valid_out and the rd_* ports in the following cycle, unless forwarding is compiled in (see Configuration).
- A CDB write and a retire may target the head in the same cycle only if the head is already ready; the ready bit is unaffected by the retire.
- Reset state: all entries cleared, head = tail = count = 0. Outputs: rob_empty=1, rob_full=0, valid_out=0, alloc_tag=0, head_tag=0, rd_ready_*=0. All data outputs are 0.
- Reset is honoured mid-operation regardless of pending inputs.

## Configuration
- ROB_CDB_FORWARD_EN, when defined:
  - If cdb_valid, cdb_tag == rd_tag_x and entry[cdb_tag].busy, then rd_ready_x = 1 and rd_value_x = cdb_value in the same cycle.
- When undefined:
  - Lookups reflect registered state only, adding one cycle of latency.
- Commit-side outputs are never forwarded in either configuration.

## Structure
- lc3b_opcode, lc3b_reg and lc3b_rob_addr are taken from lc3b_types.
- Add to lc3b_types:
  - rob_entry_t, a packed struct of the entry fields.
  - ROB_DEPTH, a constant equal to 2**tag_width.
- One sub-module, rob_ptr: a wrapping tag_width counter with increment and clear inputs, instantiated for head and tail.

## Test plan
- Reset, then allocate 8 entries with opcode op_add, dest = i -> alloc_tag goes 0..7, rob_full=1 after the 8th, and a 9th alloc is ignored.
- CDB writes tag 2 with value 0x1234, then tag 0 with 0x0042 -> valid_out=1 only once tag 0 is ready; value_out=0x0042, head_tag=0.
- Full ROB with head ready, asserting alloc and RE together -> retire occurs, allocation refused, count=7. On the next cycle alloc is accepted at tag 0 (wrap).
- Five occupied entries with flush, alloc, cdb_valid and RE asserted together -> next cycle rob_empty=1, head_tag=alloc_tag=0, valid_out=0.
- With ROB_CDB_FORWARD_EN, rd_tag_a=3 while the CDB writes tag 3 with 0xBEEF -> same cycle rd_ready_a=1, rd_value_a=0xBEEF. Without the macro, both values appear one cycle later.
- Assert rst_n low mid-stream with three entries busy -> outputs immediately show reset values, without waiting for a clock edge.
